// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants for the 4-bit-opcode CPU: opcodes, the
//               multi-cycle sequencer state encoding, and the PC-source and
//               writeback-source mux encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   // Opcodes carried in IR[3:0]
   localparam logic [3:0] OP_ALUR   = 4'h0;
   localparam logic [3:0] OP_CMPR   = 4'h2;
   localparam logic [3:0] OP_SW     = 4'h5;
   localparam logic [3:0] OP_BRANCH = 4'h6;
   localparam logic [3:0] OP_ALUI   = 4'h8;
   localparam logic [3:0] OP_LW     = 4'h9;
   localparam logic [3:0] OP_CMPI   = 4'hA;
   localparam logic [3:0] OP_JAL    = 4'hB;

   // Sequencer states; codes 6 and 7 are unused
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   // PC source select
   localparam logic [1:0] PC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_BR    = 2'd1;
   localparam logic [1:0] PC_JAL   = 2'd2;

   // Writeback source select
   localparam logic [1:0] WB_ALU   = 2'd0;
   localparam logic [1:0] WB_MEM   = 2'd1;
   localparam logic [1:0] WB_LINK  = 2'd2;

   // True for every opcode the datapath implements
   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         OP_ALUR, OP_ALUI, OP_LW, OP_SW,
         OP_CMPR, OP_CMPI, OP_BRANCH, OP_JAL: op_legal = 1'b1;
         default:                             op_legal = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Multi-cycle control FSM. Steps each instruction through
//               FETCH/DECODE/EXEC/MEM/WB, drives IR/PC/RF enables and the
//               shared memory port (req/ready), flags illegal opcodes and
//               counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer
   import cpu_pkg::*;
#(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          op,
   input  logic                cond_true,
   input  logic                mem_ready,
   output logic                ir_we,
   output logic                pc_we,
   output logic [1:0]          pc_src,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_addr_sel,
   output logic                rf_we,
   output logic [1:0]          wb_sel,
   output logic                illegal,
   output logic [2:0]          state,
   output logic [RETIRE_W-1:0] retired
);

   state_t                r_state;
   state_t                w_next;
   logic                  r_illegal;
   logic [RETIRE_W-1:0]   r_retired;
   logic                  w_set_illegal;

   // Next state and control strobes; reset masks every strobe so nothing
   // is written or requested during an abandoned instruction
   always_comb begin
      w_next        = r_state;
      w_set_illegal = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_src        = PC_PLUS4;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr_sel  = 1'b0;
      rf_we         = 1'b0;
      wb_sel        = WB_ALU;

      case (r_state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we  = 1'b1;
               w_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (op_legal(op)) begin
               w_next = S_EXEC;
            end else begin
               w_set_illegal = 1'b1;
               w_next        = S_HALT;
            end
         end
         S_EXEC: begin
            if (op == OP_LW || op == OP_SW) begin
               w_next = S_MEM;
            end else if (op == OP_BRANCH) begin
               pc_we  = 1'b1;
               pc_src = cond_true ? PC_BR : PC_PLUS4;
               w_next = S_FETCH;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            // Address select and store qualifier depend only on state/op,
            // so they stay stable for the whole wait
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (op == OP_SW);
            if (mem_ready) begin
               if (op == OP_SW) begin
                  pc_we  = 1'b1;
                  w_next = S_FETCH;
               end else begin
                  w_next = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we  = 1'b1;
            pc_we  = 1'b1;
            wb_sel = (op == OP_LW)  ? WB_MEM :
                     (op == OP_JAL) ? WB_LINK : WB_ALU;
            pc_src = (op == OP_JAL) ? PC_JAL : PC_PLUS4;
            w_next = S_FETCH;
         end
         S_HALT: begin
            w_next = S_HALT;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase

      if (reset) begin
         w_set_illegal = 1'b0;
         ir_we         = 1'b0;
         pc_we         = 1'b0;
         pc_src        = PC_PLUS4;
         mem_req       = 1'b0;
         mem_we        = 1'b0;
         mem_addr_sel  = 1'b0;
         rf_we         = 1'b0;
         wb_sel        = WB_ALU;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Sticky illegal-opcode flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_illegal <= 1'b0;
      end else if (w_set_illegal) begin
         r_illegal <= 1'b1;
      end
   end

   // Retired-instruction counter: one retire per PC update, wraps naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         r_retired <= '0;
      end else if (pc_we) begin
         r_retired <= r_retired + RETIRE_W'(1);
      end
   end

   assign state   = r_state;
   assign illegal = r_illegal;
   assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Directed self-checking bench for multicycle_sequencer. Each
//               step drives inputs, queues the expected state/strobes/flags
//               and compares them against the DUT mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

   logic        clk;
   logic        reset;
   logic [3:0]  op;
   logic        cond_true;
   logic        mem_ready;
   logic        ir_we;
   logic        pc_we;
   logic [1:0]  pc_src;
   logic        mem_req;
   logic        mem_we;
   logic        mem_addr_sel;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic        illegal;
   logic [2:0]  state;
   logic [31:0] retired;

   // Control vector order: {ir_we, pc_we, pc_src, mem_req, mem_we,
   //                        mem_addr_sel, rf_we, wb_sel}
   localparam logic [9:0] C_NONE    = 10'b0_0_00_0_0_0_0_00;
   localparam logic [9:0] C_F_WAIT  = 10'b0_0_00_1_0_0_0_00;
   localparam logic [9:0] C_F_GO    = 10'b1_0_00_1_0_0_0_00;
   localparam logic [9:0] C_M_LD    = 10'b0_0_00_1_0_1_0_00;
   localparam logic [9:0] C_M_ST_GO = 10'b0_1_00_1_1_1_0_00;
   localparam logic [9:0] C_WB_ALU  = 10'b0_1_00_0_0_0_1_00;
   localparam logic [9:0] C_WB_LW   = 10'b0_1_00_0_0_0_1_01;
   localparam logic [9:0] C_WB_JAL  = 10'b0_1_10_0_0_0_1_10;
   localparam logic [9:0] C_BR_T    = 10'b0_1_01_0_0_0_0_00;
   localparam logic [9:0] C_BR_N    = 10'b0_1_00_0_0_0_0_00;

   typedef struct {
      string       tag;
      logic [45:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests;
   int   n_fail;

   multicycle_sequencer #(.RETIRE_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .op           (op),
      .cond_true    (cond_true),
      .mem_ready    (mem_ready),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_src       (pc_src),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .rf_we        (rf_we),
      .wb_sel       (wb_sel),
      .illegal      (illegal),
      .state        (state),
      .retired      (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock cycle: drive inputs just after the edge, queue the
   // expectation, compare mid-cycle, then advance to the next edge
   task automatic step(input string tag, input logic rst_in, input logic mr,
                       input logic ct, input logic [2:0] e_state,
                       input logic [9:0] e_ctrl, input logic e_ill,
                       input logic [31:0] e_ret);
      exp_t        e;
      logic [45:0] obs;
      reset     = rst_in;
      mem_ready = mr;
      cond_true = ct;
      exp_q.push_back('{tag, {e_state, e_ctrl, e_ill, e_ret}});
      #3;
      e   = exp_q.pop_front();
      obs = {state, ir_we, pc_we, pc_src, mem_req, mem_we, mem_addr_sel,
             rf_we, wb_sel, illegal, retired};
      n_tests++;
      assert (obs === e.val) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      reset     = 1'b1;
      op        = 4'h0;
      cond_true = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      // Reset: strobes masked even with mem_ready high
      step("reset",        1'b1, 1'b1, 1'b0, 3'd0, C_NONE,    1'b0, 32'd0);

      // ALUR, zero-wait memory
      op = 4'h0;
      step("alur_fetch",   1'b0, 1'b1, 1'b0, 3'd0, C_F_GO,    1'b0, 32'd0);
      step("alur_decode",  1'b0, 1'b1, 1'b0, 3'd1, C_NONE,    1'b0, 32'd0);
      step("alur_exec",    1'b0, 1'b1, 1'b0, 3'd2, C_NONE,    1'b0, 32'd0);
      step("alur_wb",      1'b0, 1'b1, 1'b0, 3'd4, C_WB_ALU,  1'b0, 32'd0);

      // LW with two wait cycles in FETCH and in MEM: 9 cycles
      op = 4'h9;
      step("lw_fwait0",    1'b0, 1'b0, 1'b0, 3'd0, C_F_WAIT,  1'b0, 32'd1);
      step("lw_fwait1",    1'b0, 1'b0, 1'b0, 3'd0, C_F_WAIT,  1'b0, 32'd1);
      step("lw_fetch",     1'b0, 1'b1, 1'b0, 3'd0, C_F_GO,    1'b0, 32'd1);
      step("lw_decode",    1'b0, 1'b1, 1'b0, 3'd1, C_NONE,    1'b0, 32'd1);
      step("lw_exec",      1'b0, 1'b1, 1'b0, 3'd2, C_NONE,    1'b0, 32'd1);
      step("lw_mwait0",    1'b0, 1'b0, 1'b0, 3'd3, C_M_LD,    1'b0, 32'd1);
      step("lw_mwait1",    1'b0, 1'b0, 1'b0, 3'd3, C_M_LD,    1'b0, 32'd1);
      step("lw_mem",       1'b0, 1'b1, 1'b0, 3'd3, C_M_LD,    1'b0, 32'd1);
      step("lw_wb",        1'b0, 1'b1, 1'b0, 3'd4, C_WB_LW,   1'b0, 32'd1);

      // SW: retires in MEM, 4 cycles
      op = 4'h5;
      step("sw_fetch",     1'b0, 1'b1, 1'b0, 3'd0, C_F_GO,    1'b0, 32'd2);
      step("sw_decode",    1'b0, 1'b1, 1'b0, 3'd1, C_NONE,    1'b0, 32'd2);
      step("sw_exec",      1'b0, 1'b1, 1'b0, 3'd2, C_NONE,    1'b0, 32'd2);
      step("sw_mem",       1'b0, 1'b1, 1'b0, 3'd3, C_M_ST_GO, 1'b0, 32'd2);

      // BRANCH taken then not taken: 3 cycles each, no WB
      op = 4'h6;
      step("brt_fetch",    1'b0, 1'b1, 1'b1, 3'd0, C_F_GO,    1'b0, 32'd3);
      step("brt_decode",   1'b0, 1'b1, 1'b1, 3'd1, C_NONE,    1'b0, 32'd3);
      step("brt_exec",     1'b0, 1'b1, 1'b1, 3'd2, C_BR_T,    1'b0, 32'd3);
      step("brn_fetch",    1'b0, 1'b1, 1'b0, 3'd0, C_F_GO,    1'b0, 32'd4);
      step("brn_decode",   1'b0, 1'b1, 1'b0, 3'd1, C_NONE,    1'b0, 32'd4);
      step("brn_exec",     1'b0, 1'b1, 1'b0, 3'd2, C_BR_N,    1'b0, 32'd4);

      // JAL: link writeback, JAL PC source
      op = 4'hB;
      step("jal_fetch",    1'b0, 1'b1, 1'b0, 3'd0, C_F_GO,    1'b0, 32'd5);
      step("jal_decode",   1'b0, 1'b1, 1'b0, 3'd1, C_NONE,    1'b0, 32'd5);
      step("jal_exec",     1'b0, 1'b1, 1'b0, 3'd2, C_NONE,    1'b0, 32'd5);
      step("jal_wb",       1'b0, 1'b1, 1'b0, 3'd4, C_WB_JAL,  1'b0, 32'd5);

      // Reset during MEM of a store: no write, no retire, ready ignored
      op = 4'h5;
      step("swr_fetch",    1'b0, 1'b1, 1'b0, 3'd0, C_F_GO,    1'b0, 32'd6);
      step("swr_decode",   1'b0, 1'b1, 1'b0, 3'd1, C_NONE,    1'b0, 32'd6);
      step("swr_exec",     1'b0, 1'b1, 1'b0, 3'd2, C_NONE,    1'b0, 32'd6);
      step("swr_rst_mem",  1'b1, 1'b1, 1'b0, 3'd3, C_NONE,    1'b0, 32'd6);
      step("swr_after",    1'b0, 1'b0, 1'b0, 3'd0, C_F_WAIT,  1'b0, 32'd0);

      // Illegal opcode: HALT with no strobes for 10 cycles, reset recovers
      op = 4'h3;
      step("ill_fetch",    1'b0, 1'b1, 1'b0, 3'd0, C_F_GO,    1'b0, 32'd0);
      step("ill_decode",   1'b0, 1'b1, 1'b0, 3'd1, C_NONE,    1'b0, 32'd0);
      for (int i = 0; i < 10; i++) begin
         step("ill_halt",  1'b0, 1'b1, 1'b1, 3'd5, C_NONE,    1'b1, 32'd0);
      end
      step("ill_rst",      1'b1, 1'b1, 1'b0, 3'd5, C_NONE,    1'b1, 32'd0);
      step("ill_recover",  1'b0, 1'b0, 1'b0, 3'd0, C_F_WAIT,  1'b0, 32'd0);

      // Counter wrap: preload all-ones before a retiring WB
      op = 4'h8;
      step("wrap_fetch",   1'b0, 1'b1, 1'b0, 3'd0, C_F_GO,    1'b0, 32'd0);
      step("wrap_decode",  1'b0, 1'b1, 1'b0, 3'd1, C_NONE,    1'b0, 32'd0);
      step("wrap_exec",    1'b0, 1'b1, 1'b0, 3'd2, C_NONE,    1'b0, 32'd0);
      force dut.r_retired = 32'hFFFF_FFFF;
      #1;
      release dut.r_retired;
      step("wrap_wb",      1'b0, 1'b1, 1'b0, 3'd4, C_WB_ALU,  1'b0, 32'hFFFF_FFFF);
      step("wrap_zero",    1'b0, 1'b0, 1'b0, 3'd0, C_F_WAIT,  1'b0, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control FSM for the 4-bit-opcode CPU datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the enables and mux selects for the IR, PC, register file and the single shared memory port. The memory port uses a req/ready handshake. The block sits beside the instruction decoder; the decoder supplies field-level controls, this block supplies timing.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.

- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 4: opcode, IR[3:0]. Stable from DECODE through the end of the instruction.
- `cond_true` in 1: ALU comparison result, valid in EXEC.
- `mem_ready` in 1: memory accepts or completes the current request this cycle.
- `ir_we` out 1: latch the instruction word.
- `pc_we` out 1: update the PC.
- `pc_src` out 2: PC source. 0 = PC+4, 1 = branch target (PC+4+imm*4), 2 = JAL target (rs1+imm*4).
- `mem_req` out 1: memory request.
- `mem_we` out 1: store qualifier, valid only while `mem_req` is high.
- `mem_addr_sel` out 1: address source. 0 = PC, 1 = ALU result.
- `rf_we` out 1: register-file write.
- `wb_sel` out 2: writeback source. 0 = ALU, 1 = memory data, 2 = PC+4 (link).
- `illegal` out 1: sticky flag, set when an undefined opcode reaches DECODE.
- `state` out 3: current FSM state, for debug.
- `retired` out `RETIRE_W`: count of completed instructions.

## Operation
- Opcodes: ALUR=0x0, ALUI=0x8, LW=0x9, SW=0x5, CMPR=0x2, CMPI=0xA, BRANCH=0x6, JAL=0xB. Every other value is illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are unreachable and recover to FETCH on the next edge.
- FETCH
  - Drive `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0.
  - If `mem_ready`=0, hold FETCH.
  - If `mem_ready`=1, drive `ir_we`=1 and go to DECODE.
- DECODE: the register file is read.
  - Legal op: go to EXEC.
  - Illegal op: set `illegal` and go to HALT.
- EXEC
  - ALUR, ALUI, CMPR, CMPI, JAL: go to WB.
  - LW, SW: go to MEM.
  - BRANCH: drive `pc_we`=1 with `pc_src` = `cond_true` ? 1 : 0, then go to FETCH. The branch retires here.
- MEM
  - Drive `mem_req`=1, `mem_addr_sel`=1, `mem_we` = (op==SW).
  - Hold MEM while `mem_ready`=0.
  - SW with `mem_ready`=1: drive `pc_we`=1, `pc_src`=0, go to FETCH. The store retires here.
  - LW with `mem_ready`=1: go to WB.
- WB
  - Drive `rf_we`=1 and `pc_we`=1.
  - `wb_sel`: 1 for LW, 2 for JAL, 0 otherwise.
  - `pc_src`: 2 for JAL, 0 otherwise.
  - Go to FETCH.
- HALT: all strobes are 0. Only `reset` exits HALT.
- Control outputs are combinational from state, `op`, `cond_true` and `mem_ready`.
- Any output not listed for a state is 0.
- `retired` increments by 1 on every cycle with `pc_we`=1 and wraps from 2^RETIRE_W-1 to 0.
- Handshake rules:
  - While `mem_req` is high, the address and `mem_we` stay stable until `mem_ready` is sampled 1.
  - `mem_ready` is ignored while `mem_req`=0.

## Timing
- Reset values: `state`=FETCH, `illegal`=0, `retired`=0. While `reset` is high, every strobe is forced to 0, including `mem_req`.
- The first `mem_req`=1 appears in the first cycle after `reset` falls.
- Cycles per instruction with zero-wait memory: ALU/CMP 4, JAL 4, BRANCH 3, SW 4, LW 5.
- Each cycle of `mem_ready`=0 while requesting adds one cycle.
- If `reset` is asserted mid-instruction:
  - The instruction is abandoned.
  - No `rf_we`, `pc_we` or memory write is issued in the reset cycle.
  - The next edge lands in FETCH.
- A `mem_ready` pulse arriving in the same cycle as `reset` is ignored.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode constants;
  - the state enum;
  - the `pc_src` encodings (PC_PLUS4, PC_BR, PC_JAL);
  - the `wb_sel` encodings (WB_ALU, WB_MEM, WB_LINK).
- The decoder imports the same opcode constants from `cpu_pkg`.
- Single module, no sub-module. The retire counter is an inline register.

## Test plan
- ALUR (op=0x0), `mem_ready` tied 1 → states 0,1,2,4,0. `ir_we` in cycle 0, `rf_we`=`pc_we`=1 with `wb_sel`=0 in cycle 3, `retired` 0→1.
- LW (op=0x9), `mem_ready` low for 2 cycles in both FETCH and MEM → 9 cycles total. `mem_addr_sel`=1, `mem_we`=0 held stable through the MEM wait. WB shows `wb_sel`=1.
- SW (op=0x5) → MEM shows `mem_we`=1. Never `rf_we`. `pc_we` with `pc_src`=0 on the MEM ready cycle. 4 cycles.
- BRANCH (op=0x6): with `cond_true`=1 → `pc_src`=1 in EXEC, 3 cycles; with `cond_true`=0 → `pc_src`=0. Neither case produces a WB state.
- JAL (op=0xB) → WB shows `wb_sel`=2, `pc_src`=2, `rf_we`=1. Illegal op=0x3 → HALT, `illegal`=1, no strobes for 10 cycles, `reset` returns to FETCH with `illegal`=0.
- `reset` asserted in MEM of an SW → no `pc_we`; `mem_req` drops that cycle; `retired` is 0 after reset. With `retired` preloaded to 0xFFFFFFFF, a retire wraps it to 0.
